bin_to_bcd4: RTL
================

Name: bin_to_bcd4

Overview:
- Iterative double-dabble converter that turns an unsigned binary result into four BCD digits plus an error code.
- Sits directly upstream of the 4-digit seven-segment driver and feeds its num0..num3 and error inputs.
- Outputs are registered and change only when a conversion completes, so the multiplexed display never shows partial values.

Parameters:
- WIDTH, 16, width of the binary input. Legal range 14..16; five internal BCD nibbles cover values up to 65535.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a conversion of value; sampled only in IDLE.
- value  input  WIDTH  unsigned binary operand; sampled on the accepting edge.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when outputs update.
- num0  output  4  thousands digit (leftmost display position).
- num1  output  4  hundreds digit.
- num2  output  4  tens digit.
- num3  output  4  ones digit.
- error  output  4  0 = valid; 1 = overflow (value > 9999). Nonzero makes the display show "Err" and the code.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE, busy = 0, done = 0.
  - num0..num3 = 0, error = 0.
  - Shift register, BCD accumulator and counter cleared.
  - A conversion in flight is abandoned.
- Internal datapath:
  - shift register sr[WIDTH-1:0].
  - 20-bit BCD accumulator bcd (nibbles d4..d0).
  - counter cnt, ceil(log2(WIDTH+1)) bits.
- State IDLE:
  - On an edge with start = 1: sr <= value, bcd <= 0, cnt <= WIDTH, busy <= 1, go to SHIFT.
  - Otherwise hold.
- State SHIFT, one bit per edge:
  - For each nibble of bcd that is >= 5, add 3 (all five nibbles in parallel, combinational).
  - Then shift {bcd, sr} left by one.
  - cnt <= cnt - 1.
  - When cnt == 1 on this edge, the last bit is shifted; go to DONE.
- State DONE, single cycle:
  - If d4 != 0 or {d3,d2,d1,d0} > 9999: error <= 1 and num0..num3 <= 0.
  - Else: error <= 0 and num0 <= d3, num1 <= d2, num2 <= d1, num3 <= d0.
  - done <= 1 for exactly one cycle, busy <= 0, go to IDLE.
- Latency:
  - Start accepted at edge k.
  - Shifts on edges k+1..k+WIDTH.
  - Outputs and done update at edge k+WIDTH+1, which is 17 edges for WIDTH = 16.
  - busy is high for cycles k..k+WIDTH.
- start while busy (SHIFT or DONE): ignored, not queued; the in-flight conversion is unaffected.
- start held high continuously: a new conversion is accepted in the first IDLE cycle after done, giving back-to-back conversions every WIDTH+2 cycles.
- value changing during SHIFT: no effect, because the operand was latched on the accepting edge.
- Between conversions, num0..num3 and error hold their last values indefinitely.
- Boundaries:
  - value = 0 gives all digits 0, error 0.
  - value = 9999 gives 9,9,9,9, error 0.
  - value = 10000 and value = 65535 both give overflow.
- Each nibble of bcd never exceeds 9 after correction. The bench asserts this every SHIFT cycle.

Test Plan:
- Reset then idle: after rst_n deasserts, num0..num3 = 0, error = 0, busy = 0, done = 0, and these hold for 50 cycles with start = 0.
- Basic conversion: start pulse with value = 1234 gives busy high for 17 cycles, then done pulses once, with num0 = 1, num1 = 2, num2 = 3, num3 = 4, error = 0.
- Boundaries:
  - value = 0 gives 0,0,0,0, error 0.
  - value = 9999 gives 9,9,9,9, error 0.
  - value = 10000 gives error = 1 and digits 0,0,0,0.
  - value = 65535 gives error = 1.
- Busy collision: start with 42, then start with 7777 pulsed 5 cycles later. Result is 0,0,4,2 and only one done pulse. value changes during SHIFT are also ignored.
- Back-to-back: start held high with value stepping 5, 10, 305. Done pulses occur 18 cycles apart, and outputs read 0,0,0,5, then 0,0,1,0, then 0,3,0,5.
- Async reset mid-operation: rst_n is asserted 8 cycles into converting 4321, between clock edges. Outputs clear immediately and no done occurs. After release, converting 4321 yields 4,3,2,1.

Source files
------------

// File: rtl/bin_to_bcd4.sv
// bin_to_bcd4: iterative double-dabble converter, binary operand to four
// BCD digits plus an overflow code; outputs move only when a conversion ends.
module bin_to_bcd4 #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] value,
   output logic             busy,
   output logic             done,
   output logic [3:0]       num0,
   output logic [3:0]       num1,
   output logic [3:0]       num2,
   output logic [3:0]       num3,
   output logic [3:0]       error
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_DONE
   } state_t;

   state_t             r_state;
   logic [WIDTH-1:0]   r_sr;
   logic [19:0]        r_bcd;
   logic [CW-1:0]      r_cnt;

   logic [19:0]        w_adj;
   logic [WIDTH+19:0]  w_next;
   logic               w_ovf;

   // add-3 correction on every nibble before the shift
   always_comb begin
      w_adj = r_bcd;
      for (int i = 0; i < 5; i++) begin
         if (r_bcd[4*i +: 4] >= 4'd5) begin
            w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
         end
      end
   end

   assign w_next = {w_adj, r_sr} << 1;
   assign w_ovf  = (r_bcd[19:16] != 4'd0) || (r_bcd[15:0] > 16'h9999);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_sr    <= '0;
         r_bcd   <= '0;
         r_cnt   <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         num0    <= 4'd0;
         num1    <= 4'd0;
         num2    <= 4'd0;
         num3    <= 4'd0;
         error   <= 4'd0;
      end else begin
         done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_sr    <= value;
                  r_bcd   <= '0;
                  r_cnt   <= CW'(WIDTH);
                  busy    <= 1'b1;
                  r_state <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               r_bcd <= w_next[WIDTH +: 20];
               r_sr  <= w_next[WIDTH-1:0];
               r_cnt <= r_cnt - CW'(1);
               if (r_cnt == CW'(1)) begin
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               if (w_ovf) begin
                  error <= 4'd1;
                  num0  <= 4'd0;
                  num1  <= 4'd0;
                  num2  <= 4'd0;
                  num3  <= 4'd0;
               end else begin
                  error <= 4'd0;
                  num0  <= r_bcd[15:12];
                  num1  <= r_bcd[11:8];
                  num2  <= r_bcd[7:4];
                  num3  <= r_bcd[3:0];
               end
               done    <= 1'b1;
               busy    <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
